// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
  localparam int SA_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic in the serial adder datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds fa_cell one bit pair per clock, LSB first.
// Optional signed-overflow output ovf_out is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  // Only the upper WIDTH-1 bits of the sum shifter are ever observed, so
  // the dead LSB is not stored.
  logic [WIDTH-2:0] sh_s_q, sh_s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_cout;
  logic [WIDTH-1:0] sh_s_full;

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  fa_cell u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign sh_s_full = {fa_s, sh_s_q};

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_a_d  = a_in;
          sh_b_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_s_d  = sh_s_full[WIDTH-1:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = sh_s_full;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (fa_s != a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); checks ovf_out when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout_out;
  logic [W-1:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation; e counts rising edges after the accepting edge.
  // A second start with other operands is pulsed at e==pulse_at (if >= 0).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int pulse_at, input string tag);
    int done_e, done_cnt, busy_cnt;
    done_e = -1; done_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
    @(posedge clk);
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      if (e == pulse_at) begin
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b0;
      end else begin
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_e < 0) done_e = e;
      end
      if (e == 4) check({tag, ".hold"}, {31'd0, cout_out} << W | 32'(sum_out),
                        {31'd0, prev_cout} << W | 32'(prev_sum));
    end
    start = 1'b0;
    check({tag, ".done_edge"}, done_e, 8);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".busy_cyc"}, busy_cnt, 9);
    check({tag, ".sum"}, 32'(sum_out), 32'(es));
    check({tag, ".cout"}, 32'(cout_out), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, ".ovf"}, 32'(ovf_out), 32'(eo));
`endif
    $display("op %s: 0x%02h+0x%02h+%0d -> sum=0x%02h cout=%0d (exp 0x%02h/%0d ovf %0d) done@%0d",
             tag, a, b, c, sum_out, cout_out, es, ec, eo, done_e);
    prev_sum = es;
    prev_cout = ec;
  endtask

  initial begin
    int q[$];
    int idle_cnt;

    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.sum", 32'(sum_out), 0);
    check("rst.cout", 32'(cout_out), 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst.ovf", 32'(ovf_out), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, -1, "0f+01");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, "ff+01");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, -1, "ff+ff+1");
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3,  "12+34_ign");

    // Reset in the middle of RUN discards the partial result.
    @(negedge clk);
    start = 1'b1; a_in = 8'h80; b_in = 8'h80; cin = 1'b0;
    @(posedge clk);
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst.pre_sum", 32'(sum_out), 32'h46);
    check("midrst.pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy), 0);
    check("midrst.done", 32'(done), 0);
    check("midrst.sum", 32'(sum_out), 0);
    check("midrst.cout", 32'(cout_out), 0);
    $display("op midrst: 0x80+0x80 aborted, sum=0x%02h busy=%0d", sum_out, busy);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0;
    prev_cout = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1, "01+01");

    // Start held high: operations accepted every WIDTH+2 edges.
    @(negedge clk);
    start = 1'b1; a_in = 8'h03; b_in = 8'h04; cin = 1'b0;
    @(posedge clk);
    idle_cnt = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (done) q.push_back(e);
      if (!busy) idle_cnt++;
    end
    start = 1'b0;
    check("b2b.done_cnt", q.size(), 3);
    check("b2b.done0", (q.size() > 0) ? q[0] : -1, 8);
    check("b2b.done1", (q.size() > 1) ? q[1] : -1, 18);
    check("b2b.done2", (q.size() > 2) ? q[2] : -1, 28);
    check("b2b.idle_cyc", idle_cnt, 3);
    check("b2b.sum", 32'(sum_out), 32'h07);
    $display("op b2b: 3 x 0x03+0x04, done pulses=%0d sum=0x%02h", q.size(), sum_out);
    repeat (12) @(negedge clk);
    prev_sum = 8'h07;
    prev_cout = 1'b0;

    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, "7f+01");
    run_op(8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0, -1, "80+7f");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
